mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage; consumes the EX/MEM register outputs (ALU result, store data, memory controls, rd, load flag).
- Performs data-memory loads/stores over a req/ack interface, sign/zero-extends load data and drives the MEM/WB pipeline register.
- Stalls upstream stages while an access is outstanding; MEM/WB outputs also feed the hazard unit forwarding path.

---
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access, load extension and the MEM/WB register.
// Defining MEM_TIMEOUT_EN adds an ack watchdog (TIMEOUT_CYCLES) driving timeout_err.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result,
    input  logic [31:0] data_for_writing_for_sw,
    input  logic        mem_enable_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic        wb_enable_mem,
    input  logic [4:0]  rd_mem,
    input  logic        ld_mem,
    input  logic [2:0]  mem_func,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_en,
    output logic        misalign_err,
    output logic        timeout_err
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [4:0]  wb_rd_q, wb_rd_d, rd_q, rd_d;
    logic        wb_en_q, wb_en_d, wben_q, wben_d, misalign_q, misalign_d;
    logic [2:0]  func_q, func_d;
    logic [1:0]  off_q, off_d;

    logic        access, aligned, timeout;
    logic [31:0] lane_wdata, shifted, load_data;
    logic [3:0]  lane_wstrb;
    logic        unused_ld;

    // Load-vs-ALU writeback is decided by mem_read_mem, so ld_mem carries no extra information.
    assign unused_ld = ld_mem;
    assign access    = mem_enable_mem & (mem_read_mem | mem_write_mem);

    always_comb begin
        unique case (mem_func[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~result[0];
            default: aligned = (result[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        lane_wdata = data_for_writing_for_sw;
        lane_wstrb = 4'b1111;
        unique case (mem_func[1:0])
            2'b00: begin
                lane_wdata = {4{data_for_writing_for_sw[7:0]}};
                lane_wstrb = 4'b0001 << result[1:0];
            end
            2'b01: begin
                lane_wdata = {2{data_for_writing_for_sw[15:0]}};
                lane_wstrb = result[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        unique case (func_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_err_q;

    assign timeout = (state_q == StWait) & ~dmem_ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (state_q == StWait) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (access && aligned) state_d = StWait;
            StWait: if (dmem_ack || timeout) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_stall  = 1'b0;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rd_d       = rd_q;
        wben_d     = wben_q;
        func_d     = func_q;
        off_d      = off_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_en_d    = 1'b0;
        misalign_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && aligned) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = ~mem_read_mem;
                    addr_d    = {result[31:2], 2'b00};
                    wdata_d   = lane_wdata;
                    wstrb_d   = lane_wstrb;
                    rd_d      = rd_mem;
                    wben_d    = wb_enable_mem;
                    func_d    = mem_func;
                    off_d     = result[1:0];
                end else if (access) begin
                    misalign_d = 1'b1;
                end else begin
                    wb_data_d = result;
                    wb_rd_d   = rd_mem;
                    wb_en_d   = wb_enable_mem & (rd_mem != 5'd0);
                end
            end
            StWait: begin
                mem_stall = ~dmem_ack & ~timeout;
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        wb_data_d = load_data;
                        wb_rd_d   = rd_q;
                        wb_en_d   = wben_q & (rd_q != 5'd0);
                    end
                end else if (timeout) begin
                    req_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_q       <= '0;
            wben_q     <= 1'b0;
            func_q     <= '0;
            off_q      <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_en_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_q       <= rd_d;
            wben_q     <= wben_d;
            func_q     <= func_d;
            off_q      <= off_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_en_q    <= wb_en_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_wstrb   = wstrb_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_en        = wb_en_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic vs a byte-level model.
module tb_mem_stage;

    logic        clk, rst;
    logic [31:0] result, data_for_writing_for_sw, dmem_rdata;
    logic        mem_enable_mem, mem_read_mem, mem_write_mem, wb_enable_mem, ld_mem, dmem_ack;
    logic [4:0]  rd_mem;
    logic [2:0]  mem_func;
    logic        dmem_req, dmem_we, mem_stall, wb_en, misalign_err, timeout_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    int vectors = 0;
    int errors  = 0;

    mem_stage #(
        .TIMEOUT_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst(rst), .result(result),
        .data_for_writing_for_sw(data_for_writing_for_sw),
        .mem_enable_mem(mem_enable_mem), .mem_read_mem(mem_read_mem),
        .mem_write_mem(mem_write_mem), .wb_enable_mem(wb_enable_mem), .rd_mem(rd_mem),
        .ld_mem(ld_mem), .mem_func(mem_func), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en), .misalign_err(misalign_err),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: access size in bytes from funct3.
    function automatic int unsigned model_size(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_aligned(input logic [2:0] f, input logic [31:0] a);
        return (a % model_size(f)) == 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f, input logic [31:0] a);
        int unsigned n = model_size(f);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
        int unsigned n = model_size(f);
        logic [31:0] w = 0;
        for (int k = 0; k < 4; k++) w = w | (((d >> (8 * (k % n))) & 32'hFF) << (8 * k));
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] r);
        logic [31:0] v = r >> (8 * (a % 4));
        case (f)
            3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = r;
        endcase
        return v;
    endfunction

    task automatic set_idle();
        mem_enable_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        wb_enable_mem  = 1'b0; ld_mem = 1'b0; rd_mem = 5'd0; mem_func = 3'd0;
        result = $urandom; data_for_writing_for_sw = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0; set_idle();
        #12;
        vectors++;
        if ({dmem_req, dmem_we, wb_en, misalign_err, timeout_err, mem_stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {dmem_req, dmem_we, wb_en, misalign_err, timeout_err, mem_stall});
        end
        vectors++;
        if ({dmem_addr, dmem_wdata, wb_data, dmem_wstrb, wb_rd} !== 105'b0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h wb_data %h strb %b rd %0d required 0",
                     dmem_addr, dmem_wdata, wb_data, dmem_wstrb, wb_rd);
        end
        @(negedge clk); rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); dmem_ack = 1'b0; #1;
        vectors++;
        if (wb_en !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_after_reset: wb_en %b req %b required 0 0", wb_en, dmem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_alu(input logic [31:0] res, input logic [4:0] rd, input logic wben);
        set_idle(); result = res; rd_mem = rd; wb_enable_mem = wben;
        mem_enable_mem = $urandom_range(0, 1); // enable without read/write is not an access
        #1;
        vectors++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got %b required 0", mem_stall);
        end
        @(negedge clk);
        vectors++;
        if (wb_data !== res || wb_rd !== rd || wb_en !== (wben && rd != 0)) begin
            errors++;
            $display("FAIL alu_wb: got %h/%0d/%b required %h/%0d/%b", wb_data, wb_rd, wb_en,
                     res, rd, (wben && rd != 0));
        end
        set_idle();
    endtask

    task automatic test_access(input logic is_load, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] d, input logic [4:0] rd, input logic wben,
                               input int delay, input logic [31:0] rdata);
        int stalls = 0;
        logic [31:0] exp_addr = a & 32'hFFFF_FFFC;
        set_idle();
        mem_enable_mem = 1'b1; mem_read_mem = is_load;
        mem_write_mem = is_load ? 1'($urandom_range(0, 1)) : 1'b1; // read wins when both set
        ld_mem = is_load; mem_func = f; result = a; data_for_writing_for_sw = d;
        rd_mem = rd; wb_enable_mem = wben;
        #1;
        stalls += int'(mem_stall);
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== !is_load || wb_en !== 0)
        begin
            errors++;
            $display("FAIL access_req: req %b addr %h we %b wb_en %b required 1 %h %b 0",
                     dmem_req, dmem_addr, dmem_we, wb_en, exp_addr, !is_load);
        end
        if (!is_load) begin
            vectors++;
            if (dmem_wstrb !== model_strb(f, a) || dmem_wdata !== model_wdata(f, d)) begin
                errors++;
                $display("FAIL store_lanes: strb %b wdata %h required %b %h", dmem_wstrb,
                         dmem_wdata, model_strb(f, a), model_wdata(f, d));
            end
        end
        for (int i = 0; i < delay; i++) begin
            #1;
            stalls += int'(mem_stall);
            vectors++;
            if (dmem_req !== 1'b1 || wb_en !== 1'b0 || dmem_addr !== exp_addr) begin
                errors++;
                $display("FAIL wait_hold: req %b wb_en %b addr %h required 1 0 %h", dmem_req,
                         wb_en, dmem_addr, exp_addr);
            end
            @(negedge clk);
        end
        dmem_ack = 1'b1; dmem_rdata = rdata; #1;
        stalls += int'(mem_stall);
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = $urandom; set_idle(); #1;
        vectors++;
        if (stalls != delay + 1) begin
            errors++; $display("FAIL stall_cycles: got %0d required %0d", stalls, delay + 1);
        end
        vectors++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL access_done: req %b stall %b required 0 0", dmem_req, mem_stall);
        end
        vectors++;
        if (is_load) begin
            if (wb_en !== (wben && rd != 0) || wb_rd !== rd || wb_data !== model_load(f, a, rdata))
            begin
                errors++;
                $display("FAIL load_wb: got %h/%0d/%b required %h/%0d/%b", wb_data, wb_rd, wb_en,
                         model_load(f, a, rdata), rd, (wben && rd != 0));
            end
        end else if (wb_en !== 1'b0) begin
            errors++; $display("FAIL store_wb: wb_en %b required 0", wb_en);
        end
        @(negedge clk);
    endtask

    task automatic test_misalign(input logic is_load, input logic [2:0] f, input logic [31:0] a);
        set_idle();
        mem_enable_mem = 1'b1; mem_read_mem = is_load; mem_write_mem = !is_load;
        mem_func = f; result = a; rd_mem = 5'd9; wb_enable_mem = 1'b1;
        #1;
        vectors++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL misalign_stall: got %b required 0", mem_stall);
        end
        @(negedge clk);
        set_idle();
        vectors++;
        if (misalign_err !== 1'b1 || dmem_req !== 1'b0 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: err %b req %b wb_en %b required 1 0 0", misalign_err,
                     dmem_req, wb_en);
        end
        @(negedge clk);
        vectors++;
        if (misalign_err !== 1'b0) begin
            errors++; $display("FAIL misalign_width: got %b required 0", misalign_err);
        end
    endtask

    task automatic test_reset_in_wait();
        set_idle();
        mem_enable_mem = 1'b1; mem_read_mem = 1'b1; mem_func = 3'd2; result = 32'h300;
        rd_mem = 5'd7; wb_enable_mem = 1'b1;
        @(negedge clk);
        set_idle(); rst = 1'b1; #1;
        vectors++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_wait: req %b stall %b wb_en %b required 0 0 0", dmem_req,
                     mem_stall, wb_en);
        end
        @(negedge clk); rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk); dmem_ack = 1'b0; #1;
        vectors++;
        if (wb_en !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: wb_en %b req %b stall %b required 0 0 0", wb_en, dmem_req,
                     mem_stall);
        end
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        set_idle();
        mem_enable_mem = 1'b1; mem_read_mem = 1'b1; mem_func = 3'd2; result = 32'h400;
        rd_mem = 5'd3; wb_enable_mem = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait: stall %b req %b err %b required 1 1 0", mem_stall,
                         dmem_req, timeout_err);
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL timeout_release: stall %b required 0", mem_stall);
        end
        @(negedge clk);
        set_idle(); #1;
        vectors++;
        if (timeout_err !== 1'b1 || dmem_req !== 1'b0 || wb_en !== 1'b0 || mem_stall !== 1'b0)
        begin
            errors++;
            $display("FAIL timeout_pulse: err %b req %b wb_en %b stall %b required 1 0 0 0",
                     timeout_err, dmem_req, wb_en, mem_stall);
        end
        @(negedge clk);
        vectors++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_width: got %b required 0", timeout_err);
        end
    endtask
`endif

    task automatic test_random(input int count);
        for (int n = 0; n < count; n++) begin
            int unsigned kind = $urandom_range(0, 2);
            logic [2:0]  f = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            if (kind == 0) begin
                test_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else if (!model_aligned(f, a)) begin
                test_misalign(kind == 1, f, a);
            end else begin
                test_access(kind == 1, f, a, $urandom, 5'($urandom_range(0, 31)),
                            1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu(32'h0000_1234, 5'd5, 1'b1);
        test_access(1'b0, 3'd0, 32'h103, 32'h0000_00AB, 5'd4, 1'b0, 3, 32'h0);
        test_access(1'b1, 3'd0, 32'h102, 32'h0, 5'd6, 1'b1, 0, 32'h0080_0000);
        test_access(1'b1, 3'd4, 32'h102, 32'h0, 5'd6, 1'b1, 0, 32'h0080_0000);
        test_access(1'b0, 3'd1, 32'h206, 32'h1357_BEEF, 5'd1, 1'b1, 1, 32'h0);
        test_access(1'b1, 3'd1, 32'h20E, 32'h0, 5'd8, 1'b1, 2, 32'h9ABC_1234);
        test_access(1'b1, 3'd2, 32'h210, 32'h0, 5'd0, 1'b1, 0, 32'hCAFE_F00D);
        test_misalign(1'b1, 3'd2, 32'h202);
        test_misalign(1'b1, 3'd1, 32'h201);
        test_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
